// File: rtl/mid_pool_reader_if.sv
// mid_pool_reader_if
//   Read side of the four-bank intermediate row buffer (mid_bram).
//   master : the reader, which drives the bank read enables and the shared read address
//            and receives the registered bank data.
//   slave  : the buffer, which receives the enables and address and returns qa/qb/qc for
//            banks 0..3.
//   Data is signed two's complement, 21 bits per channel.
interface mid_pool_reader_if;
  logic                in0_rden;
  logic                in1_rden;
  logic                in2_rden;
  logic                in3_rden;
  logic        [10:0]  rd_addr;
  logic signed [20:0]  qa_0, qa_1, qa_2, qa_3;
  logic signed [20:0]  qb_0, qb_1, qb_2, qb_3;
  logic signed [20:0]  qc_0, qc_1, qc_2, qc_3;

  modport master (
    output in0_rden, in1_rden, in2_rden, in3_rden, rd_addr,
    input  qa_0, qa_1, qa_2, qa_3,
    input  qb_0, qb_1, qb_2, qb_3,
    input  qc_0, qc_1, qc_2, qc_3
  );

  modport slave (
    input  in0_rden, in1_rden, in2_rden, in3_rden, rd_addr,
    output qa_0, qa_1, qa_2, qa_3,
    output qb_0, qb_1, qb_2, qb_3,
    output qc_0, qc_1, qc_2, qc_3
  );
endinterface

// File: rtl/mid_pool_reader.sv
// mid_pool_reader
//   Reads a completed row pair from the two banks the writer has released. It then
//   performs signed 2x2 max-pooling on channels a/b/c and streams image_width/2 pooled
//   pixels per row pair.
//   Ports:
//     clk, RESET   : single clock, synchronous active-high reset
//     fin_rd       : one-cycle pulse, a row pair is ready
//     bram_toggle  : sampled with fin_rd; 1 selects banks 0/1, 0 selects banks 2/3
//     bram         : buffer read side (rden x4, rd_addr, q data x12)
//     pool_a/b/c   : pooled pixel, signed, held between de_out pulses
//     de_out       : pooled pixel valid, one cycle per pixel
//     busy         : high from first read cycle through the last de_out
//     frame_done   : one-cycle pulse after the last pixel of the frame's last row pair
//     overrun      : sticky, fin_rd arrived while a pair was still being processed
module mid_pool_reader #(
  parameter logic [10:0] image_width  = 11'd28,
  parameter logic [10:0] image_height = 11'd28
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                fin_rd,
  input  logic                bram_toggle,
  mid_pool_reader_if.master   bram,
  output logic signed [20:0]  pool_a,
  output logic signed [20:0]  pool_b,
  output logic signed [20:0]  pool_c,
  output logic                de_out,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  // Travels alongside each read address until its data returns from the banks.
  typedef struct packed {
    logic valid;
    logic odd;
    logic last;
    logic sel;
  } tag_t;

  state_t state, state_nxt;
  tag_t   tag_issue, tag_d1, tag_d2;

  logic        sel;
  logic [10:0] rd_addr_r;
  logic [10:0] pair_cnt;
  logic        out_last;
  logic        last_addr, done, accept, pair_wrap;

  logic signed [20:0] top_a, bot_a, top_b, bot_b, top_c, bot_c;
  logic signed [20:0] col_a, col_b, col_c;
  logic signed [20:0] hold_a, hold_b, hold_c;

  function automatic logic signed [20:0] smax(input logic signed [20:0] x,
                                              input logic signed [20:0] y);
    return (x > y) ? x : y;
  endfunction

  assign last_addr = (rd_addr_r == image_width - 11'd1);
  assign pair_wrap = ((pair_cnt + 11'd1) >= (image_height >> 1));

  // Pair completes on the last pooled pixel, or, for odd widths, when the dropped
  // final column has returned (it is read but never emitted).
  assign done   = (tag_d2.valid && tag_d2.last && !tag_d2.odd) || (de_out && out_last);
  assign accept = fin_rd && ((state == IDLE) || ((state == DRAIN) && done));

  // State register
  always_ff @(posedge clk) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (fin_rd)    state_nxt = READ;
      READ:    if (last_addr) state_nxt = DRAIN;
      DRAIN:   if (done)      state_nxt = fin_rd ? READ : IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy          = (state != IDLE);
    bram.in0_rden = (state == READ) &&  sel;
    bram.in1_rden = (state == READ) &&  sel;
    bram.in2_rden = (state == READ) && !sel;
    bram.in3_rden = (state == READ) && !sel;
    bram.rd_addr  = rd_addr_r;
  end

  always_comb begin
    tag_issue       = '0;
    tag_issue.valid = (state == READ);
    tag_issue.odd   = rd_addr_r[0];
    tag_issue.last  = last_addr;
    tag_issue.sel   = sel;
  end

  // Even bank holds the top row, odd bank the bottom row.
  always_comb begin
    top_a = tag_d2.sel ? bram.qa_0 : bram.qa_2;
    bot_a = tag_d2.sel ? bram.qa_1 : bram.qa_3;
    top_b = tag_d2.sel ? bram.qb_0 : bram.qb_2;
    bot_b = tag_d2.sel ? bram.qb_1 : bram.qb_3;
    top_c = tag_d2.sel ? bram.qc_0 : bram.qc_2;
    bot_c = tag_d2.sel ? bram.qc_1 : bram.qc_3;
    col_a = smax(top_a, bot_a);
    col_b = smax(top_b, bot_b);
    col_c = smax(top_c, bot_c);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      sel        <= 1'b0;
      rd_addr_r  <= '0;
      tag_d1     <= '0;
      tag_d2     <= '0;
      hold_a     <= '0;
      hold_b     <= '0;
      hold_c     <= '0;
      pool_a     <= '0;
      pool_b     <= '0;
      pool_c     <= '0;
      de_out     <= 1'b0;
      out_last   <= 1'b0;
      pair_cnt   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (accept) sel <= bram_toggle;
      rd_addr_r  <= ((state == READ) && !last_addr) ? rd_addr_r + 11'd1 : '0;
      tag_d1     <= tag_issue;
      tag_d2     <= tag_d1;
      de_out     <= 1'b0;
      frame_done <= 1'b0;

      if (tag_d2.valid) begin
        if (!tag_d2.odd) begin
          hold_a <= col_a;
          hold_b <= col_b;
          hold_c <= col_c;
        end else begin
          pool_a   <= smax(hold_a, col_a);
          pool_b   <= smax(hold_b, col_b);
          pool_c   <= smax(hold_c, col_c);
          de_out   <= 1'b1;
          out_last <= tag_d2.last;
        end
      end

      if ((state == DRAIN) && done) begin
        if (pair_wrap) begin
          pair_cnt   <= '0;
          frame_done <= 1'b1;
        end else begin
          pair_cnt   <= pair_cnt + 11'd1;
        end
      end

      if (fin_rd && !accept) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mid_pool_reader.sv
// tb_mid_pool_reader
//   Two instances: d0 with width 28 / height 28, d1 with width 5 / height 4.
//   A behavioural two-cycle bank memory feeds each instance. Expected pooled values
//   are the plain max over each 2x2 window of the bank contents.
module tb_mid_pool_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               RESET;
  logic               fin [2];
  logic               tog [2];
  logic signed [20:0] pa [2];
  logic signed [20:0] pb [2];
  logic signed [20:0] pc [2];
  logic               de [2];
  logic               bsy [2];
  logic               fd [2];
  logic               ovr [2];
  logic [10:0]        addr_o [2];
  logic [3:0]         rden_o [2];

  logic signed [20:0] mem [2][4][3][28];

  longint pool_m [2][3];
  bit     ovr_m [2];
  int     pair_m [2];
  bit     fd_pend [2];

  int n_checks = 0;
  int n_fail   = 0;

  mid_pool_reader_if bif [2] ();

  mid_pool_reader #(.image_width(11'd28), .image_height(11'd28)) u_dut0 (
    .clk(clk), .RESET(RESET), .fin_rd(fin[0]), .bram_toggle(tog[0]), .bram(bif[0]),
    .pool_a(pa[0]), .pool_b(pb[0]), .pool_c(pc[0]), .de_out(de[0]), .busy(bsy[0]),
    .frame_done(fd[0]), .overrun(ovr[0])
  );

  mid_pool_reader #(.image_width(11'd5), .image_height(11'd4)) u_dut1 (
    .clk(clk), .RESET(RESET), .fin_rd(fin[1]), .bram_toggle(tog[1]), .bram(bif[1]),
    .pool_a(pa[1]), .pool_b(pb[1]), .pool_c(pc[1]), .de_out(de[1]), .busy(bsy[1]),
    .frame_done(fd[1]), .overrun(ovr[1])
  );

  // Bank memory: address registered, then data registered. Disabled banks return noise.
  for (genvar g = 0; g < 2; g++) begin : g_bank
    int                 a_d;
    logic [3:0]         en_d;
    logic signed [20:0] q_r [4][3];

    assign rden_o[g] = {bif[g].in3_rden, bif[g].in2_rden, bif[g].in1_rden, bif[g].in0_rden};
    assign addr_o[g] = bif[g].rd_addr;

    always @(posedge clk) begin
      a_d  <= int'(bif[g].rd_addr);
      en_d <= rden_o[g];
      for (int b = 0; b < 4; b++)
        for (int ch = 0; ch < 3; ch++)
          q_r[b][ch] <= (en_d[b] && a_d < 28) ? mem[g][b][ch][a_d] : 21'($urandom);
    end

    assign bif[g].qa_0 = q_r[0][0];
    assign bif[g].qa_1 = q_r[1][0];
    assign bif[g].qa_2 = q_r[2][0];
    assign bif[g].qa_3 = q_r[3][0];
    assign bif[g].qb_0 = q_r[0][1];
    assign bif[g].qb_1 = q_r[1][1];
    assign bif[g].qb_2 = q_r[2][1];
    assign bif[g].qb_3 = q_r[3][1];
    assign bif[g].qc_0 = q_r[0][2];
    assign bif[g].qc_1 = q_r[1][2];
    assign bif[g].qc_2 = q_r[2][2];
    assign bif[g].qc_3 = q_r[3][2];
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wid(input int d);
    return (d == 0) ? 28 : 5;
  endfunction

  function automatic int hgt(input int d);
    return (d == 0) ? 28 : 4;
  endfunction

  function automatic longint max4(input longint a, input longint b, input longint c,
                                  input longint e);
    longint m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (e > m) m = e;
    return m;
  endfunction

  function automatic logic signed [20:0] rnd();
    int v;
    case ($urandom % 3)
      0:       return 21'($urandom);
      1: begin v = int'($urandom_range(0, 6)) - 3; return 21'(v); end
      default: return ($urandom % 2) ? 21'h0FFFFF : 21'h100000;
    endcase
  endfunction

  task automatic fill_pair(input int d, input bit tg);
    int b0;
    b0 = tg ? 0 : 2;
    for (int b = b0; b < b0 + 2; b++)
      for (int ch = 0; ch < 3; ch++)
        for (int col = 0; col < 28; col++)
          mem[d][b][ch][col] = rnd();
  endtask

  task automatic reset_models();
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 3; ch++) pool_m[d][ch] = 0;
      ovr_m[d]   = 1'b0;
      pair_m[d]  = 0;
      fd_pend[d] = 1'b0;
    end
  endtask

  task automatic check_rst(input int d, input string where);
    check_eq({where, " rd_addr"},    longint'(addr_o[d]), 0);
    check_eq({where, " rden"},       longint'(rden_o[d]), 0);
    check_eq({where, " de_out"},     longint'(de[d]), 0);
    check_eq({where, " busy"},       longint'(bsy[d]), 0);
    check_eq({where, " frame_done"}, longint'(fd[d]), 0);
    check_eq({where, " overrun"},    longint'(ovr[d]), 0);
    check_eq({where, " pool_a"},     longint'(pa[d]), 0);
    check_eq({where, " pool_b"},     longint'(pb[d]), 0);
    check_eq({where, " pool_c"},     longint'(pc[d]), 0);
  endtask

  task automatic start(input int d, input bit tg);
    @(negedge clk);
    fin[d] = 1'b1;
    tog[d] = tg;
  endtask

  // Follows one row pair cycle by cycle after its fin_rd edge T (cycle c = T+c).
  task automatic watch(input int d, input bit tg, input int ovr_at, input bit chain,
                       input bit next_tg, input int rst_at);
    int       w, npix, busy_end, end_c, top;
    longint   ex [14][3];
    bit       wrap, in_rst, exp_de, exp_fd;
    logic [3:0] sel_rden;
    string    tg_s;
    w        = wid(d);
    npix     = w / 2;
    busy_end = (w + 2 > 3 + 2 * npix) ? w + 2 : 3 + 2 * npix;
    top      = tg ? 0 : 2;
    for (int k = 0; k < npix; k++)
      for (int ch = 0; ch < 3; ch++)
        ex[k][ch] = max4(mem[d][top][ch][2*k], mem[d][top][ch][2*k+1],
                         mem[d][top+1][ch][2*k], mem[d][top+1][ch][2*k+1]);
    wrap     = (pair_m[d] + 1 >= hgt(d) / 2);
    sel_rden = tg ? 4'b0011 : 4'b1100;
    end_c    = chain ? busy_end : busy_end + 1;
    if (rst_at > 0) end_c = rst_at + 8;
    in_rst   = 1'b0;
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      fin[d] = 1'b0;
      tg_s = $sformatf("d%0d c%0d", d, c);
      if (rst_at > 0 && c == rst_at + 1) begin
        RESET  = 1'b0;
        in_rst = 1'b1;
        reset_models();
      end
      if (in_rst) begin
        check_rst(d, {tg_s, " rst"});
      end else begin
        exp_de = (c >= 5) && ((c - 5) % 2 == 0) && ((c - 5) / 2 < npix);
        if (exp_de)
          for (int ch = 0; ch < 3; ch++) pool_m[d][ch] = ex[(c - 5) / 2][ch];
        exp_fd = (c == 1 && fd_pend[d]) || (c == busy_end + 1 && wrap);
        check_eq({tg_s, " rd_addr"},    longint'(addr_o[d]), (c <= w) ? c - 1 : 0);
        check_eq({tg_s, " rden"},       longint'(rden_o[d]), (c <= w) ? sel_rden : 0);
        check_eq({tg_s, " de_out"},     longint'(de[d]), longint'(exp_de));
        check_eq({tg_s, " busy"},       longint'(bsy[d]), longint'(c <= busy_end));
        check_eq({tg_s, " frame_done"}, longint'(fd[d]), longint'(exp_fd));
        check_eq({tg_s, " overrun"},    longint'(ovr[d]), longint'(ovr_m[d]));
        check_eq({tg_s, " pool_a"},     longint'(pa[d]), pool_m[d][0]);
        check_eq({tg_s, " pool_b"},     longint'(pb[d]), pool_m[d][1]);
        check_eq({tg_s, " pool_c"},     longint'(pc[d]), pool_m[d][2]);
      end
      if (c == ovr_at) begin
        fin[d]   = 1'b1;
        ovr_m[d] = 1'b1;
      end
      if (chain && c == busy_end) begin
        fin[d] = 1'b1;
        tog[d] = next_tg;
      end
      if (c == rst_at) RESET = 1'b1;
    end
    if (rst_at == 0) begin
      pair_m[d]  = wrap ? 0 : pair_m[d] + 1;
      fd_pend[d] = wrap && chain;
    end
  endtask

  initial begin
    bit tg, nxt, ch_now, chained;
    int vals [4];

    RESET = 1'b1;
    for (int d = 0; d < 2; d++) begin
      fin[d] = 1'b0;
      tog[d] = 1'b0;
    end
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 4; b++)
        for (int ch = 0; ch < 3; ch++)
          for (int col = 0; col < 28; col++)
            mem[d][b][ch][col] = '0;
    reset_models();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rst(0, "reset d0");
    check_rst(1, "reset d1");
    RESET = 1'b0;
    repeat (2) @(negedge clk);

    // Ramp pattern on banks 0/1, channel a.
    fill_pair(0, 1'b1);
    for (int col = 0; col < 28; col++) begin
      mem[0][0][0][col] = 21'(col);
      mem[0][1][0][col] = 21'(100 + col);
    end
    start(0, 1'b1);
    watch(0, 1'b1, 0, 1'b0, 1'b0, 0);
    check_eq("ramp last pool_a", longint'(pa[0]), 127);

    // Signed windows on banks 2/3.
    vals = '{-5, -1, -1048576, 3};
    for (int col = 0; col < 28; col++) begin
      mem[0][2][0][col] = 21'(vals[col % 4]);
      mem[0][3][0][col] = 21'h100000;
      mem[0][2][1][col] = (col % 2 == 0) ? 21'(-7) : 21'(-2);
      mem[0][3][1][col] = (col % 2 == 0) ? 21'(-9) : 21'(-4);
      mem[0][2][2][col] = 21'h100000;
      mem[0][3][2][col] = (col == 27) ? 21'h100001 : 21'h100000;
    end
    start(0, 1'b0);
    watch(0, 1'b0, 0, 1'b0, 1'b0, 0);
    check_eq("neg window pool_b", longint'(pb[0]), -2);
    check_eq("min edge pool_c",   longint'(pc[0]), -1048575);

    // Random pairs.
    for (int i = 0; i < 3; i++) begin
      tg = 1'($urandom);
      fill_pair(0, tg);
      start(0, tg);
      watch(0, tg, 0, 1'b0, 1'b0, 0);
    end

    // Overrun at T+10, then a back-to-back request at the earliest accepted edge.
    tg = 1'($urandom);
    fill_pair(0, tg);
    fill_pair(0, !tg);
    start(0, tg);
    watch(0, tg, 10, 1'b1, !tg, 0);
    watch(0, !tg, 0, 1'b0, 1'b0, 0);

    // Fourteen further pairs, some back-to-back, crossing a frame boundary.
    chained = 1'b0;
    tg = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (!chained) tg = 1'($urandom);
      fill_pair(0, tg);
      if (!chained) start(0, tg);
      nxt    = !tg;
      ch_now = (i % 4 == 1) && (i < 13);
      watch(0, tg, 0, ch_now, nxt, 0);
      chained = ch_now;
      tg      = nxt;
    end

    // Reset mid-pair, then a fresh pair.
    tg = 1'($urandom);
    fill_pair(0, tg);
    start(0, tg);
    watch(0, tg, 0, 1'b0, 1'b0, 12);
    fill_pair(0, !tg);
    start(0, !tg);
    watch(0, !tg, 0, 1'b0, 1'b0, 0);

    // Odd width on the second instance.
    chained = 1'b0;
    tg = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!chained) tg = 1'($urandom);
      fill_pair(1, tg);
      if (!chained) start(1, tg);
      nxt    = !tg;
      ch_now = (i == 2);
      watch(1, tg, 0, ch_now, nxt, 0);
      chained = ch_now;
      tg      = nxt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mid_pool_reader.md
# mid_pool_reader

Downstream consumer of the four-bank intermediate row buffer (`mid_bram`). On each `fin_rd` pulse it reads the just-completed row pair from the two banks the writer has left, for all three channels (a/b/c). It performs signed 2x2 max-pooling and streams `image_width/2` pooled pixels per row pair to the next layer. It owns the buffer's read side: `in0..in3_rden` and `rd_addr`.

## Interface
- `image_width`, 11'd28, pixels per row; odd widths drop the last column.
- `image_height`, 11'd28, rows per frame; used only for the frame-done pulse.
- `clk  in  1`  single clock; all logic on posedge.
- `RESET  in  1`  reset; synchronous, active-high.
- `fin_rd  in  1`  one-cycle pulse from buffer: a row pair is complete.
- `bram_toggle  in  1`  sampled with `fin_rd`: 1 → read banks 0/1, 0 → read banks 2/3.
- `qa_0..qa_3, qb_0..qb_3, qc_0..qc_3  in  21 each`  bank read data, signed two's complement.
- `in0_rden, in1_rden, in2_rden, in3_rden  out  1 each`  bank read enables.
- `rd_addr  out  11`  shared read address.
- `pool_a, pool_b, pool_c  out  21 each`  pooled outputs, signed.
- `de_out  out  1`  pooled pixel valid, one cycle per pixel.
- `busy  out  1`  high from first read cycle through last `de_out`.
- `frame_done  out  1`  one-cycle pulse after the last pixel of the last row pair of a frame.
- `overrun  out  1`  sticky; set when `fin_rd` arrives while `busy`.

## Operation
- FSM states:
  - IDLE: wait for `fin_rd`. On `fin_rd`, latch `sel = bram_toggle` and go to READ.
  - READ: drive `rd_addr` 0..`image_width`-1, one per cycle, with the rden pair for `sel` held high. After address `image_width`-1, go to DRAIN.
  - DRAIN: wait for the 2-cycle read pipeline and the final pool to emit, then return to IDLE.
- Bank roles: even bank (0 or 2) is the top row, odd bank (1 or 3) is the bottom row.
- Only the selected pair has rden high; the other two rdens stay 0 at all times.
- Read latency: q for an address is valid 2 cycles after the address cycle. A valid-tag shift register tracks the address, column parity and last-column flag.
- Pool per channel: even column computes `m = max(top, bot)` into a holding register. The following odd column outputs `max(m, top, bot)`.
- All compares are signed 21-bit. No saturation and no width growth.
- Output count per pair is `image_width >> 1`.
- Row-pair counter: increments on each completed pair and wraps at `image_height/2`-1 → 0. `frame_done` pulses on the cycle after the wrapping pair's last `de_out`.
- `fin_rd` while `busy`: request is dropped, `overrun` is set and stays set until `RESET`, and the current pair completes unaffected.
- `fin_rd` in the same cycle the FSM returns to IDLE: accepted.
- `RESET` mid-operation: on the next edge go to IDLE and clear the pipeline tags, counters and `overrun`. No further `de_out` appears.

## Timing
- Reset values: `rden*`=0, `rd_addr`=0, `pool_*`=0, `de_out`=0, `busy`=0, `frame_done`=0, `overrun`=0, FSM=IDLE.
- `fin_rd` is sampled at edge T:
  - cycles T+1..T+W: `rd_addr` = n at cycle T+1+n, rden pair high.
  - `rd_addr` returns to 0 and rden to 0 at T+W+1.
  - data for address n is valid at T+3+n.
  - pooled pixel k is registered at edge T+4+2k: `de_out`=1 and `pool_*` valid during cycle T+5+2k.
- W=28 gives `de_out` at T+5, T+7, …, T+31; `busy` high T+1..T+31. Earliest accepted next `fin_rd` is at edge T+31.
- `pool_*` holds its value between `de_out` pulses.

## Test plan
- Single pair, W=28, `fin_rd` with `bram_toggle`=1, bank0 qa = col, bank1 qa = 100+col → 14 `de_out` at T+5+2k, `pool_a` = 101,103,…,127. `in2/in3_rden` never high.
- Signed compare, toggle=0, banks 2/3, per-column values −5, −1, −1048576 (0x100000), 3 → `pool_*` = max with correct sign. Check an all-negative window, e.g. −7, −2, −9, −4 → −2.
- Overrun: second `fin_rd` at T+10 → ignored, `overrun`=1 sticky, exactly 14 outputs. Next `fin_rd` at T+31 → accepted.
- Frame wrap, image_height=28: 14 consecutive pairs → `frame_done` pulses once, one cycle after the 14th pair's last `de_out`. Pair counter returns to 0.
- `RESET` at T+12 → from T+13 all outputs at reset values, no further `de_out`. A fresh `fin_rd` produces 14 correct outputs.
- Odd width, image_width=5 → 2 outputs at T+5, T+7. Column 4 is read but not emitted, and `busy` drops after T+7.
